// File: rtl/csi_pkg.sv
// -----------------------------------------------------------------------------
// csi_pkg
// Shared definitions for the CSI-2 packet parser:
//   - data type constants for the short-packet sync codes and the long-packet
//     threshold
//   - the parser FSM state encoding
//   - csi_ecc(): 6-bit CSI-2 Hamming parity over the 24-bit header
//     {WC[15:0], DI[7:0]}
// -----------------------------------------------------------------------------
package csi_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR1     = 2'd1,
    PAYLOAD  = 2'd2,
    WAIT_END = 2'd3
  } state_e;

  // d[7:0] = DI, d[23:8] = WC. Each parity bit covers a fixed subset of the
  // header bits; P5..P0 form the low six bits of the ECC byte.
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi_ecc_check.sv
// -----------------------------------------------------------------------------
// csi_ecc_check
// Combinational header integrity check. Flags an error when the received ECC
// byte does not match the Hamming parity of the header, or when its two
// reserved upper bits are non-zero. Detection only, no correction.
// Instantiated by csi_packet_parser only when CSI_ECC_CHECK_EN is defined.
//   header  in  24  {WC[15:0], DI[7:0]}
//   ecc     in  8   received ECC byte
//   err     out 1   1 = header corrupt
// -----------------------------------------------------------------------------
module csi_ecc_check
  import csi_pkg::*;
(
  input  logic [23:0] header,
  input  logic [7:0]  ecc,
  output logic        err
);

  assign err = (ecc[7:6] != 2'b00) || (ecc[5:0] != csi_ecc(header));

endmodule

// File: rtl/csi_packet_parser.sv
// -----------------------------------------------------------------------------
// csi_packet_parser
// Splits the aligned 2-lane word stream into CSI-2 packets. The 32-bit header
// arrives as two words (H0 = {WC[7:0], DI}, H1 = {ECC, WC[15:8]}); short
// packets produce frame/line sync pulses, long packets produce a
// byte-qualified payload stream. CRC/trailer words are skipped until the
// burst ends (word_valid low). All outputs are registered.
//
// Optional feature: define CSI_ECC_CHECK_EN to check the header ECC; bad
// headers raise header_err and are otherwise dropped. Without it the ECC byte
// is ignored and header_err is tied low.
//
// Parameters:
//   VC_ANY  1 = accept every virtual channel, 0 = accept only VC_SEL
//   VC_SEL  virtual channel accepted when VC_ANY = 0
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   word_in[15:0]        [7:0] lane-0 byte (earlier), [15:8] lane-1 byte
//   word_valid           high for the whole HS burst
//   frame_start/frame_end/line_start/line_end   one-cycle sync pulses
//   pkt_vc/pkt_dt/pkt_wc fields of the last accepted header
//   payload_data/strb/valid/last   payload stream, 1-cycle latency
//   header_err           one-cycle pulse on ECC mismatch
//   pkt_abort            one-cycle pulse when the burst ends mid-payload
// -----------------------------------------------------------------------------
module csi_packet_parser
  import csi_pkg::*;
#(
  parameter bit         VC_ANY = 1'b1,
  parameter logic [1:0] VC_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [1:0]  pkt_vc,
  output logic [5:0]  pkt_dt,
  output logic [15:0] pkt_wc,
  output logic [15:0] payload_data,
  output logic [1:0]  payload_strb,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        header_err,
  output logic        pkt_abort
);

  state_e      state_q, state_d;
  logic [15:0] h0_q, h0_d;
  logic [15:0] bytes_left_q, bytes_left_d;

  logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] pd_q, pd_d;
  logic [1:0]  strb_q, strb_d;
  logic        pv_q, pv_d, last_q, last_d, abort_q, abort_d;

  // Header fields, valid while in HDR1 with H1 on word_in.
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic        vc_ok;

  assign hdr_di = h0_q[7:0];
  assign hdr_wc = {word_in[7:0], h0_q[15:8]};
  assign hdr_vc = hdr_di[7:6];
  assign hdr_dt = hdr_di[5:0];
  assign vc_ok  = VC_ANY || (hdr_vc == VC_SEL);

`ifdef CSI_ECC_CHECK_EN
  logic ecc_err;
  logic herr_q, herr_d;

  csi_ecc_check u_ecc_check (
    .header ({hdr_wc, hdr_di}),
    .ecc    (word_in[15:8]),
    .err    (ecc_err)
  );
`endif

  always_comb begin
    // NOTE: every next-state value is defaulted before any branch so that no
    // path leaves a variable unassigned and infers a latch.
    state_d      = state_q;
    h0_d         = h0_q;
    bytes_left_d = bytes_left_q;
    fs_d         = 1'b0;
    fe_d         = 1'b0;
    ls_d         = 1'b0;
    le_d         = 1'b0;
    vc_d         = vc_q;
    dt_d         = dt_q;
    wc_d         = wc_q;
    pd_d         = pd_q;
    strb_d       = 2'b00;
    pv_d         = 1'b0;
    last_d       = 1'b0;
    abort_d      = 1'b0;
`ifdef CSI_ECC_CHECK_EN
    herr_d       = 1'b0;
`endif

    if (!word_valid) begin
      // Burst ended. Only a burst ending inside the payload is an abort;
      // in PAYLOAD the final word has by definition not yet been seen.
      state_d = IDLE;
      if (state_q == PAYLOAD) abort_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          h0_d    = word_in;
          state_d = HDR1;
        end

        HDR1: begin
          state_d = WAIT_END;
`ifdef CSI_ECC_CHECK_EN
          if (ecc_err) begin
            herr_d = 1'b1;
          end else
`endif
          if (vc_ok) begin
            vc_d = hdr_vc;
            dt_d = hdr_dt;
            wc_d = hdr_wc;
            if (hdr_dt < DT_LONG_MIN) begin
              case (hdr_dt)
                DT_FS:   fs_d = 1'b1;
                DT_FE:   fe_d = 1'b1;
                DT_LS:   ls_d = 1'b1;
                DT_LE:   le_d = 1'b1;
                default: ;
              endcase
            end else if (hdr_wc != 16'd0) begin
              bytes_left_d = hdr_wc;
              state_d      = PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          pd_d = word_in;
          pv_d = 1'b1;
          if (bytes_left_q >= 16'd2) begin
            strb_d       = 2'b11;
            bytes_left_d = bytes_left_q - 16'd2;
          end else begin
            strb_d       = 2'b01;
            bytes_left_d = 16'd0;
          end
          if (bytes_left_q <= 16'd2) begin
            last_d  = 1'b1;
            state_d = WAIT_END;
          end
        end

        WAIT_END: ;  // CRC and trailer words are dropped

        default: state_d = IDLE;
      endcase
    end
  end

  // Synchronous reset: a reset mid-packet simply discards it, no abort pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (!resetn) begin
      state_q      <= IDLE;
      h0_q         <= '0;
      bytes_left_q <= '0;
      fs_q         <= 1'b0;
      fe_q         <= 1'b0;
      ls_q         <= 1'b0;
      le_q         <= 1'b0;
      vc_q         <= '0;
      dt_q         <= '0;
      wc_q         <= '0;
      pd_q         <= '0;
      strb_q       <= '0;
      pv_q         <= 1'b0;
      last_q       <= 1'b0;
      abort_q      <= 1'b0;
`ifdef CSI_ECC_CHECK_EN
      herr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      h0_q         <= h0_d;
      bytes_left_q <= bytes_left_d;
      fs_q         <= fs_d;
      fe_q         <= fe_d;
      ls_q         <= ls_d;
      le_q         <= le_d;
      vc_q         <= vc_d;
      dt_q         <= dt_d;
      wc_q         <= wc_d;
      pd_q         <= pd_d;
      strb_q       <= strb_d;
      pv_q         <= pv_d;
      last_q       <= last_d;
      abort_q      <= abort_d;
`ifdef CSI_ECC_CHECK_EN
      herr_q       <= herr_d;
`endif
    end
  end

  assign frame_start   = fs_q;
  assign frame_end     = fe_q;
  assign line_start    = ls_q;
  assign line_end      = le_q;
  assign pkt_vc        = vc_q;
  assign pkt_dt        = dt_q;
  assign pkt_wc        = wc_q;
  assign payload_data  = pd_q;
  assign payload_strb  = strb_q;
  assign payload_valid = pv_q;
  assign payload_last  = last_q;
  assign pkt_abort     = abort_q;
`ifdef CSI_ECC_CHECK_EN
  assign header_err    = herr_q;
`else
  assign header_err    = 1'b0;
`endif

endmodule

// File: tb/tb_csi_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_csi_packet_parser
// Two parser instances share one input stream: dut_a accepts every VC,
// dut_b accepts only VC 1. Each scenario builds a beat stream, plays it, and
// compares every cycle of both instances against a burst-level model that
// works on whole bursts by index arithmetic (header = first two beats,
// ceil(WC/2) payload beats follow, a short burst means abort).
// Header ECC checks are exercised when CSI_ECC_CHECK_EN is defined.
// -----------------------------------------------------------------------------
module tb_csi_packet_parser;

  logic        clk;
  logic        resetn;
  logic        word_valid;
  logic [15:0] word_in;

  typedef struct packed {
    logic        fs, fe, ls, le, herr, abort, pv, last;
    logic [1:0]  strb;
    logic [15:0] pd;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
  } obs_t;

  typedef struct packed {
    logic        v;
    logic [15:0] w;
  } beat_t;

  logic        fs_a, fe_a, ls_a, le_a, herr_a, abort_a, pv_a, last_a;
  logic [1:0]  strb_a, vc_a;
  logic [5:0]  dt_a;
  logic [15:0] pd_a, wc_a;
  logic        fs_b, fe_b, ls_b, le_b, herr_b, abort_b, pv_b, last_b;
  logic [1:0]  strb_b, vc_b;
  logic [5:0]  dt_b;
  logic [15:0] pd_b, wc_b;

  csi_packet_parser #(.VC_ANY(1'b1), .VC_SEL(2'd0)) dut_a (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_valid(word_valid),
    .frame_start(fs_a), .frame_end(fe_a), .line_start(ls_a), .line_end(le_a),
    .pkt_vc(vc_a), .pkt_dt(dt_a), .pkt_wc(wc_a),
    .payload_data(pd_a), .payload_strb(strb_a), .payload_valid(pv_a),
    .payload_last(last_a), .header_err(herr_a), .pkt_abort(abort_a)
  );

  csi_packet_parser #(.VC_ANY(1'b0), .VC_SEL(2'd1)) dut_b (
    .clk(clk), .resetn(resetn), .word_in(word_in), .word_valid(word_valid),
    .frame_start(fs_b), .frame_end(fe_b), .line_start(ls_b), .line_end(le_b),
    .pkt_vc(vc_b), .pkt_dt(dt_b), .pkt_wc(wc_b),
    .payload_data(pd_b), .payload_strb(strb_b), .payload_valid(pv_b),
    .payload_last(last_b), .header_err(herr_b), .pkt_abort(abort_b)
  );

  obs_t cur_a, cur_b;
  assign cur_a = {fs_a, fe_a, ls_a, le_a, herr_a, abort_a, pv_a, last_a,
                  strb_a, pd_a, vc_a, dt_a, wc_a};
  assign cur_b = {fs_b, fe_b, ls_b, le_b, herr_b, abort_b, pv_b, last_b,
                  strb_b, pd_b, vc_b, dt_b, wc_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t       stream[$];
  obs_t        act_a[$], act_b[$], exp_a[$], exp_b[$];
  logic [23:0] m_pkt[2];  // model's held {vc, dt, wc} per instance

  // Parity masks over {WC, DI}: ECC bit i = XOR of the header bits in mask i.
  localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                           24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 6; i++) e[i] = ^(d & ECC_MASK[i]);
    return e;
  endfunction

  function automatic void push_hdr(input logic [7:0] di, input logic [15:0] wc,
                                   input logic [7:0] flip);
    stream.push_back({1'b1, wc[7:0], di});
    stream.push_back({1'b1, ref_ecc({wc, di}) ^ flip, wc[15:8]});
  endfunction

  function automatic void push_word(input logic [15:0] w);
    stream.push_back({1'b1, w});
  endfunction

  function automatic void push_gap(input int n);
    for (int i = 0; i < n; i++) stream.push_back({1'b0, 16'h0000});
  endfunction

  // Payload data/strb only matter while valid, and only enabled bytes count.
  function automatic obs_t norm(input obs_t o);
    obs_t r;
    r = o;
    if (!r.pv) begin
      r.pd   = '0;
      r.strb = '0;
    end else if (!r.strb[1]) begin
      r.pd[15:8] = '0;
    end
    return r;
  endfunction

  // Burst-level reference: e[t] is the output expected after clock edge t.
  task automatic build_expected(input int which, input bit vc_any,
                                input logic [1:0] vc_sel);
    obs_t        e[$];
    bit          upd[$];
    logic [23:0] newp[$];
    obs_t        o;
    logic [23:0] cur;
    logic [15:0] h0, h1, wc;
    logic [7:0]  di;
    int          t, b, len, nwords, idx, n;
    n = stream.size();
    for (int i = 0; i < n; i++) begin
      e.push_back('0);
      upd.push_back(1'b0);
      newp.push_back('0);
    end
    t = 0;
    while (t < n) begin
      if (!stream[t].v) begin
        t++;
        continue;
      end
      b = t;
      while (t < n && stream[t].v) t++;
      len = t - b;
      if (len < 2) continue;
      h0 = stream[b].w;
      h1 = stream[b+1].w;
      di = h0[7:0];
      wc = {h1[7:0], h0[15:8]};
`ifdef CSI_ECC_CHECK_EN
      if (h1[15:8] != ref_ecc({wc, di})) begin
        o = e[b+1]; o.herr = 1'b1; e[b+1] = o;
        continue;
      end
`endif
      if (!vc_any && di[7:6] != vc_sel) continue;
      upd[b+1]  = 1'b1;
      newp[b+1] = {di, wc};
      if (di[5:0] < 6'h10) begin
        o = e[b+1];
        case (di[5:0])
          6'h00: o.fs = 1'b1;
          6'h01: o.fe = 1'b1;
          6'h02: o.ls = 1'b1;
          6'h03: o.le = 1'b1;
          default: ;
        endcase
        e[b+1] = o;
        continue;
      end
      nwords = (int'(wc) + 1) / 2;
      for (int i = 0; i < nwords && i < len - 2; i++) begin
        idx    = b + 2 + i;
        o      = e[idx];
        o.pv   = 1'b1;
        o.pd   = stream[idx].w;
        o.last = (i == nwords - 1);
        o.strb = (i == nwords - 1 && wc[0]) ? 2'b01 : 2'b11;
        e[idx] = o;
      end
      if (len - 2 < nwords) begin
        o = e[b+len]; o.abort = 1'b1; e[b+len] = o;
      end
    end
    cur = m_pkt[which];
    for (int i = 0; i < n; i++) begin
      if (upd[i]) cur = newp[i];
      o = e[i];
      {o.vc, o.dt, o.wc} = cur;
      e[i] = o;
    end
    m_pkt[which] = cur;
    if (which == 0) exp_a = e;
    else            exp_b = e;
  endtask

  // Play the stream (plus a closing idle beat), record both instances, and
  // build the expected traces.
  task automatic run_stream();
    push_gap(1);
    act_a.delete();
    act_b.delete();
    for (int t = 0; t <= stream.size(); t++) begin
      @(negedge clk);
      if (t > 0) begin
        act_a.push_back(cur_a);
        act_b.push_back(cur_b);
      end
      if (t < stream.size()) begin
        word_valid = stream[t].v;
        word_in    = stream[t].v ? stream[t].w : 16'($urandom);
      end
    end
    word_valid = 1'b0;
    build_expected(0, 1'b1, 2'd0);
    build_expected(1, 1'b0, 2'd1);
    stream.delete();
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    word_valid = 1'b0;
    word_in    = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cur_a !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset dut_a got=%h want=0", cur_a);
    end
    n_cmp++;
    if (cur_b !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset dut_b got=%h want=0", cur_b);
    end
    resetn   = 1'b1;
    m_pkt[0] = '0;
    m_pkt[1] = '0;
    @(negedge clk);
  endtask

  task automatic test_frame_start();
    push_hdr(8'h00, 16'h0000, 8'h00);
    run_stream();
    n_cmp++;
    if (act_a[1].fs !== 1'b1 || act_a[2].fs !== 1'b0 || act_a[1].pv !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_start pulse got fs1=%b fs2=%b pv=%b want 1 0 0",
               act_a[1].fs, act_a[2].fs, act_a[1].pv);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL frame_start a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL frame_start b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_raw8();
    push_hdr(8'h2A, 16'd4, 8'h00);
    push_word(16'h2211);
    push_word(16'h4433);
    push_word(16'($urandom));  // CRC
    run_stream();
    n_cmp++;
    if (act_a[2].pd !== 16'h2211 || act_a[2].strb !== 2'b11 || act_a[2].last !== 1'b0 ||
        act_a[3].pd !== 16'h4433 || act_a[3].strb !== 2'b11 || act_a[3].last !== 1'b1 ||
        act_a[4].pv !== 1'b0) begin
      n_bad++;
      $display("FAIL raw8 beats got %h/%b/%b %h/%b/%b want 2211/11/0 4433/11/1",
               act_a[2].pd, act_a[2].strb, act_a[2].last,
               act_a[3].pd, act_a[3].strb, act_a[3].last);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL raw8 a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL raw8 b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_odd_wc();
    push_hdr(8'h2A, 16'd3, 8'h00);
    push_word(16'h2211);
    push_word(16'hA533);
    push_word(16'($urandom));
    run_stream();
    n_cmp++;
    if (act_a[3].strb !== 2'b01 || act_a[3].last !== 1'b1 || act_a[3].pd[7:0] !== 8'h33) begin
      n_bad++;
      $display("FAIL odd_wc final got strb=%b last=%b byte=%h want 01 1 33",
               act_a[3].strb, act_a[3].last, act_a[3].pd[7:0]);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL odd_wc a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL odd_wc b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_abort();
    push_hdr(8'h2A, 16'd8, 8'h00);
    push_word(16'h1111);
    push_word(16'h2222);
    push_gap(1);
    push_hdr(8'h02, 16'h0007, 8'h00);  // line start right after
    run_stream();
    n_cmp++;
    if (act_a[4].abort !== 1'b1 || act_a[3].last !== 1'b0 || act_a[6].ls !== 1'b1) begin
      n_bad++;
      $display("FAIL abort got abort=%b last=%b ls=%b want 1 0 1",
               act_a[4].abort, act_a[3].last, act_a[6].ls);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL abort a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL abort b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_vc_filter();
    push_hdr(8'h00, 16'h0000, 8'h00);  // FS on VC0
    push_gap(1);
    push_hdr(8'h40, 16'h0000, 8'h00);  // FS on VC1
    run_stream();
    n_cmp++;
    if (act_b[1].fs !== 1'b0 || act_b[4].fs !== 1'b1 || act_b[4].vc !== 2'd1) begin
      n_bad++;
      $display("FAIL vc_filter got fs_vc0=%b fs_vc1=%b vc=%0d want 0 1 1",
               act_b[1].fs, act_b[4].fs, act_b[4].vc);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL vc_filter a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL vc_filter b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_short_types();
    push_hdr(8'h01, 16'h0010, 8'h00); push_word(16'hBEEF); push_gap(1);  // FE
    push_hdr(8'h42, 16'h0011, 8'h00); push_gap(1);                       // LS, VC1
    push_hdr(8'h83, 16'h0012, 8'h00); push_gap(1);                       // LE, VC2
    push_hdr(8'h08, 16'hABCD, 8'h00); push_gap(1);                       // generic short
    push_hdr(8'h2A, 16'h0000, 8'h00); push_word(16'h1234); push_gap(1);  // long, WC=0
    push_gap(1);
    push_word(16'h0000);                                                  // lone H0
    run_stream();
    n_cmp++;
    if (act_a[1].fe !== 1'b1 || act_a[1].wc !== 16'h0010) begin
      n_bad++;
      $display("FAIL short_types fe=%b wc=%h want 1 0010", act_a[1].fe, act_a[1].wc);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL short_types a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL short_types b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    push_hdr(8'h2A, 16'd4, 8'h00);
    push_word(16'hA1A0); push_word(16'hA3A2); push_word(16'($urandom));
    push_gap(1);
    push_hdr(8'h6B, 16'd6, 8'h00);
    push_word(16'hB1B0); push_word(16'hB3B2); push_word(16'hB5B4);
    run_stream();
    n_cmp++;
    if (act_a[8].pv !== 1'b1 || act_a[8].pd !== 16'hB1B0 || act_b[10].last !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_back got pv=%b pd=%h last_b=%b want 1 B1B0 1",
               act_a[8].pv, act_a[8].pd, act_b[10].last);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL back_to_back a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL back_to_back b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

`ifdef CSI_ECC_CHECK_EN
  task automatic test_ecc();
    push_hdr(8'h03, 16'h5555, 8'h00); push_gap(1);  // good LE
    push_hdr(8'h02, 16'h1234, 8'h01); push_gap(1);  // LS, ECC bit 0 flipped
    push_hdr(8'h2A, 16'd2, 8'h80); push_word(16'h7777);  // reserved ECC bit set
    run_stream();
    n_cmp++;
    if (act_a[4].herr !== 1'b1 || act_a[4].ls !== 1'b0 ||
        act_a[4].dt !== 6'h03 || act_a[4].wc !== 16'h5555) begin
      n_bad++;
      $display("FAIL ecc got herr=%b ls=%b dt=%h wc=%h want 1 0 03 5555",
               act_a[4].herr, act_a[4].ls, act_a[4].dt, act_a[4].wc);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL ecc a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL ecc b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  di, flip;
    logic [15:0] wc;
    bit          is_short;
    int          n;
    for (int p = 0; p < 40; p++) begin
      di       = 8'($urandom);
      is_short = ($urandom_range(0, 3) == 0);
      di[5:0]  = is_short ? 6'($urandom_range(0, 15)) : 6'($urandom_range(16, 63));
      wc       = is_short ? 16'($urandom) : 16'($urandom_range(0, 24));
      flip     = ($urandom_range(0, 6) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      push_hdr(di, wc, flip);
      n = is_short ? 0 : (int'(wc) + 1) / 2;
      if (n > 0 && $urandom_range(0, 4) == 0) n = $urandom_range(0, n - 1);
      else n += $urandom_range(0, 2);
      for (int i = 0; i < n; i++) push_word(16'($urandom));
      push_gap($urandom_range(1, 3));
    end
    run_stream();
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL random a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL random b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  task automatic test_wc_max();
    push_hdr(8'h6A, 16'hFFFF, 8'h00);
    for (int i = 0; i < 32768; i++) push_word(16'($urandom));
    push_word(16'($urandom));  // CRC
    run_stream();
    n_cmp++;
    if (act_a[32768].strb !== 2'b11 || act_a[32768].last !== 1'b0 ||
        act_a[32769].strb !== 2'b01 || act_a[32769].last !== 1'b1 ||
        act_a[32770].pv !== 1'b0) begin
      n_bad++;
      $display("FAIL wc_max tail got %b/%b %b/%b pv=%b want 11/0 01/1 0",
               act_a[32768].strb, act_a[32768].last, act_a[32769].strb,
               act_a[32769].last, act_a[32770].pv);
    end
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL wc_max a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL wc_max b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  // Reset in the middle of a payload: everything clears, no abort follows.
  task automatic test_reset_mid();
    logic [15:0] words [5];
    words = '{16'h082A, {ref_ecc(24'h00082A), 8'h00}, 16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      word_valid = 1'b1;
      word_in    = words[i];
    end
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    word_valid = 1'b0;
    n_cmp++;
    if (cur_a !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_mid held got=%h want=0", cur_a);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cur_a !== obs_t'(0) || cur_b !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_mid release got a=%h b=%h want 0", cur_a, cur_b);
    end
    m_pkt[0] = '0;
    m_pkt[1] = '0;
    push_hdr(8'h01, 16'h0042, 8'h00);
    run_stream();
    for (int t = 0; t < act_a.size(); t++) begin
      n_cmp += 2;
      if (norm(act_a[t]) !== norm(exp_a[t])) begin
        n_bad++; $display("FAIL reset_mid a t=%0d got=%h want=%h", t, act_a[t], exp_a[t]);
      end
      if (norm(act_b[t]) !== norm(exp_b[t])) begin
        n_bad++; $display("FAIL reset_mid b t=%0d got=%h want=%h", t, act_b[t], exp_b[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_raw8();
    test_odd_wc();
    test_abort();
    test_vc_filter();
    test_short_types();
    test_back_to_back();
`ifdef CSI_ECC_CHECK_EN
    test_ecc();
`endif
    test_random();
    test_wc_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
